// File: rtl/transpose_collect.sv
// transpose_collect: assembles a serial element stream into DEPTH-wide rows
// with a valid/ready handshake on the row output.
module transpose_collect #(
    parameter int DEPTH = 8,
    parameter int BITS  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic signed [BITS-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic signed [BITS-1:0] out_data [DEPTH-1:0],
    input  logic                   out_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [CW-1:0] cnt;
    logic signed [BITS-1:0] row [DEPTH-1:0];
    logic free, accept, xfer_last, xfer_full, load;
    always_comb begin
        in_ready  = cnt < CW'(DEPTH);
        free      = !out_valid || out_ready;
        accept    = in_valid && in_ready && !clr;
        xfer_last = accept && free && cnt == CW'(DEPTH - 1);
        xfer_full = !clr && free && cnt == CW'(DEPTH);
        load      = xfer_last || xfer_full;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                row[i]      <= '0;
                out_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (accept && cnt == CW'(i)) row[i] <= in_data;
            // the last element bypasses the buffer so the row leaves one cycle after it arrives
            if (load) begin
                for (int i = 0; i < DEPTH; i++)
                    out_data[i] <= (xfer_last && i == DEPTH - 1) ? in_data : row[i];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            cnt <= (clr || load) ? '0 : accept ? cnt + 1'b1 : cnt;
        end
    end
endmodule

// File: tb/tb_transpose_collect.sv
// tb_transpose_collect: directed self-checking bench for transpose_collect (DEPTH=4, BITS=8).
module tb_transpose_collect;
    logic clk = 1'b0;
    logic rst = 1'b1, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic signed [7:0] in_data = '0;
    logic in_ready, out_valid;
    logic signed [7:0] out_data [3:0];
    int passed = 0, total = 0;

    transpose_collect #(.DEPTH(4), .BITS(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic chk_row(input string tag, input logic [7:0] e0, e1, e2, e3);
        chk({tag, "[0]"}, out_data[0], e0);
        chk({tag, "[1]"}, out_data[1], e1);
        chk({tag, "[2]"}, out_data[2], e2);
        chk({tag, "[3]"}, out_data[3], e3);
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ov", {7'd0, out_valid}, 8'd0);
        chk("rst_ir", {7'd0, in_ready}, 8'd1);
        chk_row("rst_row", 8'd0, 8'd0, 8'd0, 8'd0);
        rst = 1'b0;

        send(8'd1); send(8'd2); send(8'd3);
        chk("r1_pre_ov", {7'd0, out_valid}, 8'd0);
        send(8'd4);
        chk("r1_ov", {7'd0, out_valid}, 8'd1);
        chk("r1_ir", {7'd0, in_ready}, 8'd1);
        chk_row("r1", 8'd1, 8'd2, 8'd3, 8'd4);

        send(8'd5); send(8'd6); send(8'd7); send(8'd8);
        chk("full_ir", {7'd0, in_ready}, 8'd0);
        chk("full_ov", {7'd0, out_valid}, 8'd1);
        chk_row("full_hold", 8'd1, 8'd2, 8'd3, 8'd4);
        out_ready = 1'b1;
        tick();
        chk("r2_ov", {7'd0, out_valid}, 8'd1);
        chk("r2_ir", {7'd0, in_ready}, 8'd1);
        chk_row("r2", 8'd5, 8'd6, 8'd7, 8'd8);

        for (int k = 0; k < 16; k++) begin
            send(8'(20 + k));
            chk("strm_ir", {7'd0, in_ready}, 8'd1);
            chk("strm_ov", {7'd0, out_valid}, (k % 4 == 3) ? 8'd1 : 8'd0);
            if (k % 4 == 3)
                chk_row("strm", 8'(17 + k), 8'(18 + k), 8'(19 + k), 8'(20 + k));
        end
        tick();
        chk("drain_ov", {7'd0, out_valid}, 8'd0);
        chk_row("drain_keep", 8'd32, 8'd33, 8'd34, 8'd35);

        out_ready = 1'b0;
        send(8'hFF); send(8'h80); send(8'h7F); send(8'h00);
        chk("sgn_ov", {7'd0, out_valid}, 8'd1);
        chk_row("sgn", 8'hFF, 8'h80, 8'h7F, 8'h00);

        send(8'd9); send(8'd10);
        clr = 1'b1;
        send(8'd11);
        clr = 1'b0;
        chk("clr_ov", {7'd0, out_valid}, 8'd1);
        chk_row("clr_keep", 8'hFF, 8'h80, 8'h7F, 8'h00);
        send(8'd12); send(8'd13); send(8'd14); send(8'd15);
        chk("clr_full_ir", {7'd0, in_ready}, 8'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("clr_row_ov", {7'd0, out_valid}, 8'd1);
        chk_row("clr_row", 8'd12, 8'd13, 8'd14, 8'd15);

        send(8'd40); send(8'd41); send(8'd42); send(8'd43);
        chk("pend_ir", {7'd0, in_ready}, 8'd0);
        clr = 1'b1;
        out_ready = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b0;
        chk("clrfull_ov", {7'd0, out_valid}, 8'd0);
        chk("clrfull_ir", {7'd0, in_ready}, 8'd1);
        chk_row("clrfull_keep", 8'd12, 8'd13, 8'd14, 8'd15);

        send(8'd50); send(8'd51); send(8'd52); send(8'd53);
        chk("pre_rst_ov", {7'd0, out_valid}, 8'd1);
        send(8'd60); send(8'd61);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ov", {7'd0, out_valid}, 8'd0);
        chk("mid_rst_ir", {7'd0, in_ready}, 8'd1);
        chk_row("mid_rst", 8'd0, 8'd0, 8'd0, 8'd0);
        send(8'd70); send(8'd71); send(8'd72); send(8'd73);
        chk("post_rst_ov", {7'd0, out_valid}, 8'd1);
        chk_row("post_rst", 8'd70, 8'd71, 8'd72, 8'd73);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/transpose_collect.md
TRANSPOSE_COLLECT -- requirements
Module: transpose_collect

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning elements per assembled row (legal DEPTH >= 2).
REQ-002 SHALL have parameter BITS, default 64, meaning width of one signed element.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port clr  input  1  synchronous discard of a partially assembled row.
REQ-006 SHALL have port in_valid  input  1  serial element offered.
REQ-007 SHALL have port in_data  input  signed BITS  serial element.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds a complete row.
REQ-010 SHALL have port out_data  output  signed BITS x DEPTH unpacked array [DEPTH-1:0]  assembled row.
REQ-011 SHALL have port out_ready  input  1  consumer takes the row this cycle.

Function
REQ-012 SHALL collect a serial element stream into parallel rows: the inverse of the team's load-parallel/shift-serial transpose FIFO.
REQ-013 SHALL accept an element on a rising edge only when in_valid and in_ready are both 1 (accept event).
REQ-014 SHALL place the k-th accepted element of a row (k = 0..DEPTH-1) at row index k: first element received -> out_data[0].
REQ-015 SHALL keep an assembly buffer of DEPTH elements plus a fill count cnt in 0..DEPTH, and a separate output register driving out_data/out_valid.
REQ-016 SHALL increment cnt by 1 per accept event; elements SHALL be stored unsigned-agnostic, bit-exact (no sign extension or arithmetic).
REQ-017 SHALL drive in_ready = 1 whenever cnt < DEPTH, combinationally from state only (no dependence on in_valid).
REQ-018 SHALL treat the output register as free on an edge when out_valid = 0, or out_valid = 1 and out_ready = 1 (drain event).
REQ-019 On the edge accepting the DEPTH-th element with the output register free: SHALL load out_data with the complete row (elements 0..DEPTH-2 from buffer, element DEPTH-1 from in_data), set out_valid = 1, set cnt = 0; latency 1 cycle (out_valid visible the cycle after the last accept).
REQ-020 On the edge accepting the DEPTH-th element with the output register not free: SHALL set cnt = DEPTH and hold the buffer; in_ready then reads 0.
REQ-021 While cnt = DEPTH: on the first edge where the output register is free, SHALL transfer the buffer to out_data, set out_valid = 1, cnt = 0.
REQ-022 SHALL keep out_data and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-023 On a drain event with no row ready to transfer, SHALL clear out_valid to 0 on that edge; out_data value thereafter is don't-care but SHALL retain its last value.
REQ-024 Drain and transfer on the same edge SHALL leave out_valid = 1 with the new row (back-to-back rows, no bubble).
REQ-025 clr = 1 SHALL set cnt = 0 on that edge, discard any element offered that cycle, and SHALL NOT affect out_valid/out_data; drain events SHALL still complete normally during clr.
REQ-026 clr while cnt = DEPTH SHALL discard the pending full row (no transfer that edge).
REQ-027 out_valid/out_ready on the output SHALL follow the standard valid/ready rule: the block never withdraws out_valid before a drain event.

Reset
REQ-028 rst = 1 at a rising edge SHALL set cnt = 0, out_valid = 0, every out_data element = 0 and every buffer element = 0; rst SHALL take priority over clr, accept and drain.
REQ-029 Following reset in_ready SHALL read 1 and the next accepted element SHALL be row index 0; reset mid-row SHALL discard the partial row.

Verification (DEPTH=4, BITS=8)
REQ-030 Reset then in_valid=1 data 1,2,3,4 on 4 consecutive cycles, out_ready=0 -> cycle after 4th accept out_valid=1, out_data[0..3]=1,2,3,4, in_ready=1.
REQ-031 Keep out_ready=0, stream 5,6,7,8 -> after 8 accepted cnt full, in_ready=0, out_data still 1,2,3,4; assert out_ready one cycle -> next cycle out_data=5,6,7,8, out_valid=1, in_ready=1.
REQ-032 out_ready held 1, stream 16 elements continuously -> in_ready never 0, four rows out in order, out_valid pulses 1 cycle each.
REQ-033 Send -1 (0xFF),-128,127,0 -> out_data = 0xFF,0x80,0x7F,0x00 bit-exact.
REQ-034 Send 9,10, then clr=1 with in_valid=1 data 11, then 12,13,14,15 -> row out = 12,13,14,15; existing out_valid row unaffected by clr.
REQ-035 Assert rst after 2 elements while out_valid=1 -> next cycle out_valid=0, all out_data=0, in_ready=1; subsequent row starts at index 0.
